// File: rtl/key_input_ctrl.sv
// DE2 pushbutton input path: synchronizes active-low keys, debounces them,
// emits press/release pulses and keeps sticky press flags for software.
module key_input_ctrl #(
  parameter int NKEYS           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_WIDTH       = 20
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NKEYS-1:0] key_n,
  input  logic [NKEYS-1:0] event_ack,
  output logic [NKEYS-1:0] key_level,
  output logic [NKEYS-1:0] key_press,
  output logic [NKEYS-1:0] key_release,
  output logic [31:0]      event_flags,
  output logic             event_valid
);

  localparam logic [CNT_WIDTH-1:0] CntMax = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [NKEYS-1:0]     sync1_q, sync2_q;
  logic [NKEYS-1:0]     stable_q, stable_d;
  logic [NKEYS-1:0]     press_q, press_d;
  logic [NKEYS-1:0]     release_q, release_d;
  logic [NKEYS-1:0]     flags_q, flags_d;
  logic [CNT_WIDTH-1:0] cnt_q [NKEYS];
  logic [CNT_WIDTH-1:0] cnt_d [NKEYS];

  // Any sample that agrees with the accepted level restarts the count, so
  // only an unbroken run of DEBOUNCE_CYCLES mismatches is accepted.
  always_comb begin
    stable_d  = stable_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < NKEYS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] < CntMax) begin
        cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
      end else begin
        cnt_d[i]     = '0;
        stable_d[i]  = sync2_q[i];
        press_d[i]   = sync2_q[i];
        release_d[i] = ~sync2_q[i];
      end
    end
    // Set is applied after the clear so a press wins over a same-cycle ack.
    flags_d = (flags_q & ~event_ack) | press_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      stable_q  <= '0;
      press_q   <= '0;
      release_q <= '0;
      flags_q   <= '0;
      for (int i = 0; i < NKEYS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= ~key_n;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      press_q   <= press_d;
      release_q <= release_d;
      flags_q   <= flags_d;
      for (int i = 0; i < NKEYS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    event_flags              = '0;
    event_flags[NKEYS-1:0]   = flags_q;
  end

  assign key_level   = stable_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign event_valid = |flags_q;

endmodule

// File: tb/tb_key_input_ctrl.sv
// Self-checking bench for key_input_ctrl: a window-based reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_key_input_ctrl;

  localparam int NK = 4;
  localparam int DB = 4;
  localparam int CW = 4;
  localparam int HL = DB + 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [NK-1:0] key_n = '1;
  logic [NK-1:0] event_ack = '0;
  logic [NK-1:0] key_level, key_press, key_release;
  logic [31:0]   event_flags;
  logic          event_valid;

  int errors = 0;
  int checks = 0;

  key_input_ctrl #(
    .NKEYS(NK),
    .DEBOUNCE_CYCLES(DB),
    .CNT_WIDTH(CW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .key_n(key_n),
    .event_ack(event_ack),
    .key_level(key_level),
    .key_press(key_press),
    .key_release(key_release),
    .event_flags(event_flags),
    .event_valid(event_valid)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [NK-1:0] keys, input logic [NK-1:0] ack);
    @(negedge clock);
    key_n     = keys;
    event_ack = ack;
  endtask

  task automatic waitPulse(input int idx, input bit isPress, output int cyc);
    logic p;
    cyc = -1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clock);
      p = isPress ? key_press[idx] : key_release[idx];
      if (p) begin
        cyc = c;
        break;
      end
    end
  endtask

  // Reference model: a key flips when the last DB synchronized samples
  // (raw samples delayed by two clocks) all disagree with its level.
  logic [NK-1:0] hist [HL];
  logic [NK-1:0] mLevel, mPress, mRel, mFlags;

  always @(posedge clock or posedge reset) begin : model
    logic [NK-1:0] nh [HL];
    logic [NK-1:0] lv, pr, rl;
    logic          allMis;
    if (reset) begin
      for (int j = 0; j < HL; j++) hist[j] <= '0;
      mLevel <= '0;
      mPress <= '0;
      mRel   <= '0;
      mFlags <= '0;
    end else begin
      nh[0] = ~key_n;
      for (int j = 1; j < HL; j++) nh[j] = hist[j-1];
      lv = mLevel;
      pr = '0;
      rl = '0;
      for (int k = 0; k < NK; k++) begin
        allMis = 1'b1;
        for (int j = 2; j < HL; j++) begin
          if (nh[j][k] == mLevel[k]) allMis = 1'b0;
        end
        if (allMis) begin
          lv[k] = ~mLevel[k];
          if (lv[k]) pr[k] = 1'b1;
          else       rl[k] = 1'b1;
        end
      end
      hist   <= nh;
      mLevel <= lv;
      mPress <= pr;
      mRel   <= rl;
      mFlags <= (mFlags & ~event_ack) | mPress;
    end
  end

  always @(negedge clock) begin
    if (!reset) begin
      checkOutput("model_level",   32'(key_level),   32'(mLevel));
      checkOutput("model_press",   32'(key_press),   32'(mPress));
      checkOutput("model_release", 32'(key_release), 32'(mRel));
      checkOutput("model_flags",   event_flags,      32'(mFlags));
      checkOutput("model_valid",   32'(event_valid), 32'(|mFlags));
    end
  end

  initial begin
    int cyc, extra, t0, t3;

    #1;
    checkOutput("reset_level", 32'(key_level), 32'h0);
    checkOutput("reset_flags", event_flags, 32'h0);
    checkOutput("reset_valid", 32'(event_valid), 32'h0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Clean press of key 0
    applyStimulus(4'b1110, 4'b0000);
    waitPulse(0, 1'b1, cyc);
    checkOutput("press0_latency", 32'(cyc), 32'd6);
    repeat (14) @(negedge clock);
    checkOutput("press0_level", 32'(key_level), 32'h1);
    checkOutput("press0_flags", event_flags, 32'h1);
    checkOutput("press0_valid", 32'(event_valid), 32'h1);

    // Bounce on key 1: 3 low, 1 high, then low
    applyStimulus(4'b1100, 4'b0000);
    applyStimulus(4'b1100, 4'b0000);
    applyStimulus(4'b1100, 4'b0000);
    applyStimulus(4'b1110, 4'b0000);
    applyStimulus(4'b1100, 4'b0000);
    waitPulse(1, 1'b1, cyc);
    checkOutput("bounce_latency", 32'(cyc), 32'd6);
    extra = 0;
    repeat (9) begin
      @(negedge clock);
      if (key_press[1]) extra++;
    end
    checkOutput("bounce_single", 32'(extra), 32'd0);
    checkOutput("bounce_flags", event_flags, 32'h3);
    applyStimulus(4'b1110, 4'b0000);
    repeat (10) @(negedge clock);

    // Release key 0, then acknowledge flags
    applyStimulus(4'b1111, 4'b0000);
    waitPulse(0, 1'b0, cyc);
    checkOutput("release0_latency", 32'(cyc), 32'd6);
    checkOutput("release0_level", 32'(key_level), 32'h0);
    repeat (3) @(negedge clock);
    checkOutput("release0_flags_sticky", event_flags, 32'h3);
    applyStimulus(4'b1111, 4'b0001);
    applyStimulus(4'b1111, 4'b0000);
    checkOutput("ack0_flags", event_flags, 32'h2);
    applyStimulus(4'b1111, 4'b0010);
    applyStimulus(4'b1111, 4'b0000);
    checkOutput("ack1_flags", event_flags, 32'h0);
    checkOutput("ack1_valid", 32'(event_valid), 32'h0);

    // Ack in the same cycle as key 2's press pulse
    applyStimulus(4'b1011, 4'b0000);
    waitPulse(2, 1'b1, cyc);
    checkOutput("press2_latency", 32'(cyc), 32'd6);
    event_ack = 4'b0100;
    @(negedge clock);
    event_ack = 4'b0000;
    checkOutput("set_wins_flags", event_flags, 32'h4);
    @(negedge clock);
    checkOutput("set_wins_hold", event_flags, 32'h4);
    applyStimulus(4'b1111, 4'b0000);
    repeat (10) @(negedge clock);
    applyStimulus(4'b1111, 4'b0100);
    applyStimulus(4'b1111, 4'b0000);
    checkOutput("ack2_flags", event_flags, 32'h0);

    // Keys 0 and 3 pressed two cycles apart
    applyStimulus(4'b1110, 4'b0000);
    t0 = -1;
    t3 = -1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clock);
      if (c == 2) key_n = 4'b0110;
      if (key_press[0]) t0 = c;
      if (key_press[3]) t3 = c;
      if (t0 >= 0 && t3 >= 0) break;
    end
    checkOutput("multi_t0", 32'(t0), 32'd6);
    checkOutput("multi_t3", 32'(t3), 32'd8);
    @(negedge clock);
    checkOutput("multi_flags", event_flags, 32'h9);
    applyStimulus(4'b0110, 4'b1000);
    applyStimulus(4'b0110, 4'b0000);
    checkOutput("multi_ack_flags", event_flags, 32'h1);

    // Reset in the middle of key 0's debounce count
    applyStimulus(4'b1111, 4'b0000);
    repeat (10) @(negedge clock);
    applyStimulus(4'b1110, 4'b0000);
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    checkOutput("midreset_level", 32'(key_level), 32'h0);
    checkOutput("midreset_press", 32'(key_press), 32'h0);
    checkOutput("midreset_flags", event_flags, 32'h0);
    checkOutput("midreset_valid", 32'(event_valid), 32'h0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    waitPulse(0, 1'b1, cyc);
    checkOutput("postreset_latency", 32'(cyc), 32'd6);
    repeat (3) @(negedge clock);
    checkOutput("postreset_flags", event_flags, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
